// File: rtl/load_store_unit_m.sv
// Memory-stage load/store unit: turns MEM-stage load/store controls into a
// registered req/ack data-memory transaction, with byte-lane strobes for stores,
// sign/zero extension for loads, a bus timeout and a pipeline stall.
module load_store_unit_m #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [2:0]  f3_q;
    logic [1:0]  lsb_q;

    logic        access, legal, misal, bad, start, expire;
    logic [31:0] st_wdata;
    logic [3:0]  st_strb;
    logic [31:0] ld_word, ld_ext;

    // Decode legality and alignment of the access presented by the MEM stage
    always_comb begin
        access = MemReadM | MemWriteM;
        if (MemWriteM) begin
            legal = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010);
        end else begin
            legal = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010) ||
                    (Funct3M == 3'b100) || (Funct3M == 3'b101);
        end
        misal  = ((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                 ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
        bad    = access && (!legal || misal);
        start  = (state_q == StIdle) && access && !bad;
        // Counter compare is only meaningful when the timeout is enabled
        expire = (TIMEOUT_CYCLES != 0) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    end

    // Replicate store data across lanes and place the strobes at the byte offset
    always_comb begin
        st_wdata = WriteDataM;
        st_strb  = 4'b1111;
        unique case (Funct3M[1:0])
            2'b00: begin
                st_wdata = {4{WriteDataM[7:0]}};
                st_strb  = 4'b0001 << ALUResultM[1:0];
            end
            2'b01: begin
                st_wdata = {2{WriteDataM[15:0]}};
                st_strb  = 4'b0011 << ALUResultM[1:0];
            end
            default: begin
                st_wdata = WriteDataM;
                st_strb  = 4'b1111;
            end
        endcase
    end

    // Shift the returned word down to the addressed byte and extend it
    always_comb begin
        ld_word = mem_rdata >> {lsb_q, 3'b000};
        unique case (f3_q)
            3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b100:  ld_ext = {24'h0, ld_word[7:0]};
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b101:  ld_ext = {16'h0, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pipeline-facing outputs
    always_comb begin
        state_d   = state_q;
        StallM    = 1'b0;
        MisalignM = 1'b0;
        ReadDataM = 32'h0;
        BusErrM   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    if (bad) begin
                        MisalignM = 1'b1;
                    end else begin
                        StallM  = 1'b1;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                StallM = 1'b1;
                // An ack coinciding with expiry is handled as a normal completion
                if (mem_ack || expire) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                ReadDataM = rdata_q;
                BusErrM   = err_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (rst) begin
            StallM    = 1'b0;
            MisalignM = 1'b0;
            ReadDataM = 32'h0;
            BusErrM   = 1'b0;
        end
    end

    // Bus registers, captured load data, timeout counter and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
            rdata_q   <= 32'h0;
            cnt_q     <= 16'h0;
            err_q     <= 1'b0;
            f3_q      <= 3'b0;
            lsb_q     <= 2'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWriteM;
                        mem_addr  <= {ALUResultM[31:2], 2'b00};
                        mem_wdata <= MemWriteM ? st_wdata : 32'h0;
                        mem_wstrb <= MemWriteM ? st_strb : 4'h0;
                        f3_q      <= Funct3M;
                        lsb_q     <= ALUResultM[1:0];
                        cnt_q     <= 16'h0;
                        err_q     <= 1'b0;
                    end
                end
                StBusy: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rdata_q <= mem_we ? 32'h0 : ld_ext;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        if (expire) begin
                            mem_req <= 1'b0;
                            rdata_q <= 32'h0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit_m.sv
// Directed bench for load_store_unit_m: expected load results are queued when
// an access is issued and compared when the unit reaches its completion cycle.
module tb_load_store_unit_m;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM;
    logic        StallM, MisalignM, BusErrM;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    load_store_unit_m #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
    endtask

    // Issue one legal access at a negedge; ack is given in BUSY cycle index ack_after
    // (negative means never). Leaves the bench at the negedge after completion.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int ack_after,
                              input logic [31:0] rdata, input int exp_busy,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                              input logic [31:0] exp_data, input logic exp_err);
        int   busy;
        exp_t e;
        sb_q.push_back('{data: exp_data, err: exp_err});
        drive(rd, wr, f3, addr, wd);
        #1;
        check({tag, "_stall_T"}, 32'(StallM), 32'd1);
        check({tag, "_misalign_T"}, 32'(MisalignM), 32'd0);
        check({tag, "_req_T"}, 32'(mem_req), 32'd0);
        @(negedge clk);
        check({tag, "_req"}, 32'(mem_req), 32'd1);
        check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, "_we"}, 32'(mem_we), 32'(wr));
        check({tag, "_wdata"}, mem_wdata, exp_wdata);
        check({tag, "_wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
        busy = 0;
        while (StallM === 1'b1 && busy < 50) begin
            check({tag, "_req_busy"}, 32'(mem_req), 32'd1);
            if (busy == ack_after) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            busy++;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
        end
        check({tag, "_busy_cycles"}, 32'(busy), 32'(exp_busy));
        e = sb_q.pop_front();
        check({tag, "_rdata"}, ReadDataM, e.data);
        check({tag, "_buserr"}, 32'(BusErrM), 32'(e.err));
        check({tag, "_req_done"}, 32'(mem_req), 32'd0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        check({tag, "_idle_stall"}, 32'(StallM), 32'd0);
        check({tag, "_idle_rdata"}, ReadDataM, 32'h0);
        check({tag, "_idle_buserr"}, 32'(BusErrM), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_stall", 32'(StallM), 32'd0);
        check("rst_rdata", ReadDataM, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_access("lw", 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1,
                   32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);
        run_access("lb", 1, 0, 3'b000, 32'h203, 32'h0, 2, 32'h80FF1234, 3,
                   32'h0, 4'b0000, 32'hFFFFFF80, 1'b0);
        run_access("lbu", 1, 0, 3'b100, 32'h203, 32'h0, 2, 32'h80FF1234, 3,
                   32'h0, 4'b0000, 32'h00000080, 1'b0);
        run_access("lh", 1, 0, 3'b001, 32'h202, 32'h0, 1, 32'h80FF1234, 2,
                   32'h0, 4'b0000, 32'hFFFF80FF, 1'b0);
        run_access("lhu", 1, 0, 3'b101, 32'h202, 32'h0, 0, 32'h80FF1234, 1,
                   32'h0, 4'b0000, 32'h000080FF, 1'b0);
        run_access("sh", 0, 1, 3'b001, 32'h42, 32'h1234ABCD, 0, 32'hFFFFFFFF, 1,
                   32'hABCDABCD, 4'b1100, 32'h0, 1'b0);
        run_access("sb", 0, 1, 3'b000, 32'h41, 32'h00000055, 1, 32'hFFFFFFFF, 2,
                   32'h55555555, 4'b0010, 32'h0, 1'b0);
        run_access("sw", 1, 1, 3'b010, 32'h84, 32'hCAFEF00D, 0, 32'h0, 1,
                   32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);

        // Misaligned word load, then illegal funct3
        drive(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
        #1;
        check("mis_flag", 32'(MisalignM), 32'd1);
        check("mis_stall", 32'(StallM), 32'd0);
        check("mis_rdata", ReadDataM, 32'h0);
        @(negedge clk);
        check("mis_req", 32'(mem_req), 32'd0);
        drive(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
        #1;
        check("ill_flag", 32'(MisalignM), 32'd1);
        check("ill_stall", 32'(StallM), 32'd0);
        @(negedge clk);
        check("ill_req", 32'(mem_req), 32'd0);
        drive(1'b0, 1'b1, 3'b001, 32'h43, 32'h1111);
        #1;
        check("mis_st_flag", 32'(MisalignM), 32'd1);
        @(negedge clk);
        check("mis_st_req", 32'(mem_req), 32'd0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);

        // Timeout with no ack, then a late ack that must be ignored
        run_access("tmo", 1, 0, 3'b010, 32'h500, 32'h0, -1, 32'h0, 4,
                   32'h0, 4'b0000, 32'h0, 1'b1);
        mem_ack = 1'b1;
        mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_req", 32'(mem_req), 32'd0);
        check("late_stall", 32'(StallM), 32'd0);
        check("late_rdata", ReadDataM, 32'h0);

        // Reset in the second BUSY cycle
        drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_req", 32'(mem_req), 32'd0);
        check("rstmid_stall", 32'(StallM), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rstmid_idle_req", 32'(mem_req), 32'd0);
        check("rstmid_idle_stall", 32'(StallM), 32'd0);
        check("rstmid_idle_rdata", ReadDataM, 32'h0);
        run_access("lw2", 1, 0, 3'b010, 32'h304, 32'h0, 0, 32'h0BADF00D, 1,
                   32'h0, 4'b0000, 32'h0BADF00D, 1'b0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
